// File: rtl/ap_adc_pkg.sv
// Shared types and constants for the audio front-end: DRP read FSM states,
// XADC DRP status-register addresses and the rate-divider width helper.
package ap_adc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT
   } drp_state_e;

   // XADC status registers: on-chip temperature and the sixteen VAUX results.
   localparam logic [6:0] XADC_TEMP   = 7'h00;
   localparam logic [6:0] XADC_VAUX0  = 7'h10;
   localparam logic [6:0] XADC_VAUX1  = 7'h11;
   localparam logic [6:0] XADC_VAUX2  = 7'h12;
   localparam logic [6:0] XADC_VAUX3  = 7'h13;
   localparam logic [6:0] XADC_VAUX4  = 7'h14;
   localparam logic [6:0] XADC_VAUX5  = 7'h15;
   localparam logic [6:0] XADC_VAUX6  = 7'h16;
   localparam logic [6:0] XADC_VAUX7  = 7'h17;
   localparam logic [6:0] XADC_VAUX8  = 7'h18;
   localparam logic [6:0] XADC_VAUX9  = 7'h19;
   localparam logic [6:0] XADC_VAUX10 = 7'h1A;
   localparam logic [6:0] XADC_VAUX11 = 7'h1B;
   localparam logic [6:0] XADC_VAUX12 = 7'h1C;
   localparam logic [6:0] XADC_VAUX13 = 7'h1D;
   localparam logic [6:0] XADC_VAUX14 = 7'h1E;
   localparam logic [6:0] XADC_VAUX15 = 7'h1F;

   function automatic int div_width(input int div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/adc_drp_sampler_tick_gen.sv
// Sample-rate counter: counts 0..DIV-1 and flags the last count as the tick.
module sample_tick_gen
   import ap_adc_pkg::*;
#(
   parameter int DIV = 12500
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CW = div_width(DIV);

   logic [CW-1:0] count_q, count_d;

   assign tick    = (count_q == CW'(DIV - 1));
   assign count_d = tick ? '0 : count_q + CW'(1);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of process ordering.
   always_ff @(posedge clk) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

endmodule

// File: rtl/adc_drp_sampler.sv
// Periodic single-register XADC DRP reader delivering audio samples, with
// sticky timeout and overrun flags.
module adc_drp_sampler
   import ap_adc_pkg::*;
#(
   parameter int         CLK_HZ       = 100_000_000,
   parameter int         SAMPLE_HZ    = 8000,
   parameter logic [6:0] CHANNEL_ADDR = XADC_VAUX3,
   parameter int         DRP_TIMEOUT  = 64,
   parameter int         DATA_WIDTH   = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr_flags,
   output logic                  drp_den,
   output logic [6:0]            drp_daddr,
   output logic                  drp_dwe,
   input  logic                  drp_drdy,
   input  logic [15:0]           drp_do,
   output logic [DATA_WIDTH-1:0] adc_data,
   output logic                  adc_valid,
   output logic                  overrun,
   output logic                  timeout
);

   localparam int DIV = CLK_HZ / SAMPLE_HZ;
   localparam int WCW = $clog2(DRP_TIMEOUT + 1);

   drp_state_e            state_q, state_d;
   logic [WCW-1:0]        wait_cnt_q, wait_cnt_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  den_q, den_d;
   logic                  valid_q, valid_d;
   logic                  overrun_q, overrun_d;
   logic                  timeout_q, timeout_d;
   logic                  tick;
   logic                  set_timeout;
   logic                  drp_do_unused;

   sample_tick_gen #(.DIV(DIV)) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      data_d      = data_q;
      valid_d     = 1'b0;
      set_timeout = 1'b0;
      case (state_q)
         IDLE: if (tick) state_d = REQ;
         REQ: begin
            state_d    = WAIT;
            wait_cnt_d = WCW'(1);
         end
         WAIT: begin
            // drdy is checked first so a response on the last allowed cycle wins.
            if (drp_drdy) begin
               data_d  = drp_do[15 -: DATA_WIDTH];
               valid_d = 1'b1;
               state_d = IDLE;
            end else if (wait_cnt_q == WCW'(DRP_TIMEOUT)) begin
               set_timeout = 1'b1;
               state_d     = IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q + WCW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      den_d     = (state_d == REQ);
      overrun_d = (tick && (state_q != IDLE)) || (overrun_q && !clr_flags);
      timeout_d = set_timeout || (timeout_q && !clr_flags);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         wait_cnt_q <= '0;
         data_q     <= '0;
         den_q      <= 1'b0;
         valid_q    <= 1'b0;
         overrun_q  <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         data_q     <= data_d;
         den_q      <= den_d;
         valid_q    <= valid_d;
         overrun_q  <= overrun_d;
         timeout_q  <= timeout_d;
      end
   end

   // Low drp_do bits carry no conversion data.
   assign drp_do_unused = ^drp_do[15-DATA_WIDTH:0];

   assign drp_den   = den_q;
   assign drp_daddr = CHANNEL_ADDR;
   assign drp_dwe   = 1'b0;
   assign adc_data  = data_q;
   assign adc_valid = valid_q;
   assign overrun   = overrun_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_adc_drp_sampler.sv
// Directed bench for adc_drp_sampler: DUT A (DIV=10, timeout 4) covers the
// read path, timeout, reset and REQ-drdy cases; DUT B (DIV=6, timeout 8) overrun.
module tb_adc_drp_sampler;

   logic        clk = 1'b0;
   logic        rst_a = 1'b1, rst_b = 1'b1;
   logic        clr_a = 1'b0, clr_b = 1'b0;
   logic        drdy_a = 1'b0, drdy_b = 1'b0;
   logic [15:0] do_a = '0, do_b = '0;
   logic        den_a, dwe_a, valid_a, ov_a, to_a;
   logic        den_b, dwe_b, valid_b, ov_b, to_b;
   logic [6:0]  addr_a, addr_b;
   logic [11:0] data_a, data_b;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   adc_drp_sampler #(.CLK_HZ(1000), .SAMPLE_HZ(100), .DRP_TIMEOUT(4)) u_dut_a (
      .clk(clk), .rst(rst_a), .clr_flags(clr_a), .drp_den(den_a), .drp_daddr(addr_a),
      .drp_dwe(dwe_a), .drp_drdy(drdy_a), .drp_do(do_a), .adc_data(data_a),
      .adc_valid(valid_a), .overrun(ov_a), .timeout(to_a));

   adc_drp_sampler #(.CLK_HZ(600), .SAMPLE_HZ(100), .DRP_TIMEOUT(8)) u_dut_b (
      .clk(clk), .rst(rst_b), .clr_flags(clr_b), .drp_den(den_b), .drp_daddr(addr_b),
      .drp_dwe(dwe_b), .drp_drdy(drdy_b), .drp_do(do_b), .adc_data(data_b),
      .adc_valid(valid_b), .overrun(ov_b), .timeout(to_b));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int n);
      while (cyc < n) step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int den_at;
      int dens;

      // 1: reset, first read with drdy two cycles after den
      step(); step();
      rst_a = 1'b0;
      cyc   = 0;
      check("rst_den",     den_a,   0);
      check("rst_data",    data_a,  0);
      check("rst_valid",   valid_a, 0);
      check("rst_flags",   {ov_a, to_a}, 0);
      check("daddr",       addr_a,  7'h13);
      check("dwe",         dwe_a,   0);
      den_at = -1;
      while (cyc < 20 && den_at < 0) begin
         step();
         if (den_a) den_at = cyc;
      end
      check("first_den_cycle", den_at, 10);
      step();
      check("den_width", den_a, 0);
      step();
      drdy_a = 1'b1; do_a = 16'hABC0;
      step();
      drdy_a = 1'b0; do_a = 16'h0000;
      check("s1_data",  data_a,  12'hABC);
      check("s1_valid", valid_a, 1);
      step();
      check("s1_valid_drop", valid_a, 0);
      run_to(19);
      check("s1_hold", data_a, 12'hABC);

      // 2: no drdy -> timeout after four WAIT cycles
      run_to(20);
      check("s2_den", den_a, 1);
      run_to(24);
      check("s2_to_early", to_a, 0);
      step();
      check("s2_timeout", to_a, 1);
      check("s2_data",    data_a, 12'hABC);
      check("s2_valid",   valid_a, 0);
      clr_a = 1'b1;
      step();
      clr_a = 1'b0;
      step();
      check("s2_clr", to_a, 0);
      run_to(30);
      check("s2_reissue", den_a, 1);
      check("s2_no_ov",   ov_a, 0);

      // 3: drdy on the last WAIT cycle wins over timeout
      run_to(34);
      drdy_a = 1'b1; do_a = 16'h1230;
      step();
      drdy_a = 1'b0;
      check("s3_data",  data_a,  12'h123);
      check("s3_valid", valid_a, 1);
      check("s3_no_to", to_a,    0);

      // 6: drdy during REQ is ignored, the next one is accepted
      run_to(40);
      check("s6_den", den_a, 1);
      drdy_a = 1'b1; do_a = 16'hFFF0;
      step();
      drdy_a = 1'b0;
      check("s6_req_ignored_valid", valid_a, 0);
      check("s6_req_ignored_data",  data_a,  12'h123);
      drdy_a = 1'b1; do_a = 16'h5A50;
      step();
      drdy_a = 1'b0;
      check("s6_data",  data_a,  12'h5A5);
      check("s6_valid", valid_a, 1);

      // 5: reset while in WAIT, late drdy after release is ignored
      run_to(50);
      check("s5_den", den_a, 1);
      run_to(52);
      rst_a = 1'b1;
      step();
      rst_a = 1'b0;
      cyc   = 0;
      check("s5_rst_data",  data_a,  0);
      check("s5_rst_valid", valid_a, 0);
      check("s5_rst_den",   den_a,   0);
      drdy_a = 1'b1; do_a = 16'h7770;
      step();
      drdy_a = 1'b0;
      check("s5_late_valid", valid_a, 0);
      step();
      check("s5_late_valid2", valid_a, 0);
      check("s5_late_data",   data_a,  0);

      // 4: DUT B, tick during WAIT sets overrun; then clr_flags
      rst_b = 1'b0;
      cyc   = 0;
      dens  = 0;
      while (cyc < 17) begin
         step();
         if (cyc == 16) clr_b = 1'b1;
         if (cyc == 17) clr_b = 1'b0;
         if (den_b) dens++;
         if (cyc == 11) check("s4_ov_before", ov_b, 0);
         if (cyc == 12) check("s4_overrun",   ov_b, 1);
         if (cyc == 15) check("s4_timeout",   to_b, 1);
      end
      check("s4_one_den",  dens, 1);
      check("s4_clr_both", {ov_b, to_b}, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
